// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and branch flush
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic [9:0]      ctrlD,
    input  logic            validD,
    input  logic [2:0]      funct3D,
    input  logic            funct7b5D,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            PCSrcE,
    output logic [9:0]      ctrlE,
    output logic            validE,
    output logic [2:0]      funct3E,
    output logic            funct7b5E,
    output logic [RA_W-1:0] Rs1E,
    output logic [RA_W-1:0] Rs2E,
    output logic [RA_W-1:0] RdE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic [15:0]     bubble_count
);
    // ctrl packing: [9] RegWrite, [8:7] ResultSrc, [6] MemWrite, [5] Jump, [4] BranchEQ, [3] BranchLT, [2:1] ALUOp, [0] ALUSrc
    logic loaduse;
    logic kill;
    assign loaduse = validE & ctrlE[9] & (ctrlE[8:7] == 2'b01) & (RdE != '0) & validD
                   & ((RdE == Rs1D) | (RdE == Rs2D));
    assign StallF  = loaduse & ~PCSrcE & ~stall_in;
    assign StallD  = StallF;
    assign FlushD  = PCSrcE & ~stall_in;
    assign kill    = PCSrcE | loaduse;

    // E-side registers: reset, hold on global stall, bubble on flush/hazard, else load D
    always_ff @(posedge clk) begin
        if (reset || (!stall_in && kill)) begin
            ctrlE     <= '0;
            validE    <= 1'b0;
            funct3E   <= '0;
            funct7b5E <= 1'b0;
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            RD1E      <= '0;
            RD2E      <= '0;
            ImmExtE   <= '0;
            PCE       <= '0;
            PCPlus4E  <= '0;
        end else if (!stall_in) begin
            ctrlE     <= validD ? ctrlD : '0;
            validE    <= validD;
            funct3E   <= funct3D;
            funct7b5E <= funct7b5D;
            Rs1E      <= Rs1D;
            Rs2E      <= Rs2D;
            RdE       <= RdD;
            RD1E      <= RD1D;
            RD2E      <= RD2D;
            ImmExtE   <= ImmExtD;
            PCE       <= PCD;
            PCPlus4E  <= PCPlus4D;
        end
    end

    // one count per inserted bubble; a simultaneous flush and hazard counts once
    always_ff @(posedge clk) begin
        if (reset)
            bubble_count <= '0;
        else if (!stall_in && kill)
            bubble_count <= bubble_count + 16'd1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset, stall_in, validD, funct7b5D, PCSrcE;
    logic [9:0]  ctrlD;
    logic [2:0]  funct3D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [9:0]  ctrlE;
    logic        validE, funct7b5E, StallF, StallD, FlushD;
    logic [2:0]  funct3E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [15:0] bubble_count;
    int passed = 0;
    int total  = 0;

    localparam logic [9:0] ADDI = 10'b1_00_0_0_0_0_10_1;
    localparam logic [9:0] LW   = 10'b1_01_0_0_0_0_00_1;
    localparam logic [9:0] ADD  = 10'b1_00_0_0_0_0_10_0;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .ctrlD(ctrlD), .validD(validD),
        .funct3D(funct3D), .funct7b5D(funct7b5D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .PCSrcE(PCSrcE), .ctrlE(ctrlE), .validE(validE), .funct3E(funct3E),
        .funct7b5E(funct7b5E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RD1E(RD1E),
        .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] c, input logic v, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] imm);
        ctrlD = c; validD = v; Rs1D = r1; Rs2D = r2; RdD = rd; ImmExtD = imm;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; PCSrcE = 1'b0;
        funct3D = 3'd5; funct7b5D = 1'b1;
        RD1D = 32'h11; RD2D = 32'h22; PCD = 32'h100; PCPlus4D = 32'h104;
        drive(ADD, 1'b1, 5'd3, 5'd4, 5'd9, 32'h55);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_ctrlE", 32'(ctrlE), 32'h0);
        chk("rst_validE", 32'(validE), 32'h0);
        chk("rst_bubbles", 32'(bubble_count), 32'h0);
        chk("rst_StallF", 32'(StallF), 32'h0);
        chk("rst_PCE", PCE, 32'h0);

        drive(ADDI, 1'b1, 5'd1, 5'd0, 5'd5, 32'd7);
        tick();
        chk("pass_ctrlE", 32'(ctrlE), 32'(ADDI));
        chk("pass_RdE", 32'(RdE), 32'd5);
        chk("pass_ImmExtE", ImmExtE, 32'd7);
        chk("pass_validE", 32'(validE), 32'd1);
        chk("pass_RD1E", RD1E, 32'h11);
        chk("pass_PCE", PCE, 32'h100);
        chk("pass_funct3E", 32'(funct3E), 32'd5);

        drive(LW, 1'b1, 5'd2, 5'd0, 5'd6, 32'd4);
        tick();
        drive(ADD, 1'b1, 5'd6, 5'd1, 5'd7, 32'd0);
        #1;
        chk("lu_StallF", 32'(StallF), 32'd1);
        chk("lu_StallD", 32'(StallD), 32'd1);
        chk("lu_FlushD", 32'(FlushD), 32'd0);
        tick();
        chk("lu_bub_ctrlE", 32'(ctrlE), 32'h0);
        chk("lu_bub_validE", 32'(validE), 32'd0);
        chk("lu_bub_count", 32'(bubble_count), 32'd1);
        chk("lu_StallF_after", 32'(StallF), 32'd0);
        tick();
        chk("lu_add_RdE", 32'(RdE), 32'd7);
        chk("lu_add_validE", 32'(validE), 32'd1);
        chk("lu_add_count", 32'(bubble_count), 32'd1);

        drive(LW, 1'b1, 5'd2, 5'd0, 5'd0, 32'd0);
        tick();
        drive(ADD, 1'b1, 5'd0, 5'd0, 5'd8, 32'd0);
        #1;
        chk("x0_StallF", 32'(StallF), 32'd0);
        tick();
        chk("x0_RdE", 32'(RdE), 32'd8);
        chk("x0_count", 32'(bubble_count), 32'd1);

        drive(LW, 1'b1, 5'd2, 5'd0, 5'd9, 32'd0);
        tick();
        drive(ADD, 1'b1, 5'd9, 5'd3, 5'd10, 32'd0);
        PCSrcE = 1'b1;
        #1;
        chk("fl_FlushD", 32'(FlushD), 32'd1);
        chk("fl_StallF", 32'(StallF), 32'd0);
        chk("fl_StallD", 32'(StallD), 32'd0);
        tick();
        chk("fl_ctrlE", 32'(ctrlE), 32'h0);
        chk("fl_validE", 32'(validE), 32'd0);
        chk("fl_count", 32'(bubble_count), 32'd2);
        PCSrcE = 1'b0;

        drive(ADD, 1'b0, 5'd1, 5'd2, 5'd11, 32'd3);
        tick();
        chk("inv_ctrlE", 32'(ctrlE), 32'h0);
        chk("inv_validE", 32'(validE), 32'd0);
        chk("inv_RdE", 32'(RdE), 32'd11);

        PCSrcE = 1'b1;
        for (int i = 0; i < 65533; i++) tick();
        chk("pre_wrap_count", 32'(bubble_count), 32'hFFFF);
        PCSrcE = 1'b0;
        drive(ADDI, 1'b1, 5'd1, 5'd0, 5'd5, 32'd7);
        tick();
        stall_in = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(LW, 1'b1, 5'(i + 12), 5'd5, 5'(i + 20), 32'(i + 100));
            #1;
            chk("st_FlushD", 32'(FlushD), 32'd0);
            chk("st_StallF", 32'(StallF), 32'd0);
            tick();
            chk("st_RdE", 32'(RdE), 32'd5);
            chk("st_ImmExtE", ImmExtE, 32'd7);
            chk("st_ctrlE", 32'(ctrlE), 32'(ADDI));
            chk("st_count", 32'(bubble_count), 32'hFFFF);
        end
        stall_in = 1'b0;
        #1;
        chk("wr_FlushD", 32'(FlushD), 32'd1);
        tick();
        chk("wr_ctrlE", 32'(ctrlE), 32'h0);
        chk("wr_validE", 32'(validE), 32'd0);
        chk("wr_ImmExtE", ImmExtE, 32'h0);
        chk("wr_count", 32'(bubble_count), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
